// File: rtl/plot_rect_engine.sv
// Rectangle rasteriser: walks a clipped fill, outline or full-screen clear
// region in raster order and emits one pixel per plot/ready handshake.
module plot_rect_engine #(
  parameter int X_W     = 8,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3,
  parameter int X_MAX   = 159,
  parameter int Y_MAX   = 119
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic [X_W-1:0]     x0_i,
  input  logic [X_W-1:0]     x1_i,
  input  logic [Y_W-1:0]     y0_i,
  input  logic [Y_W-1:0]     y1_i,
  input  logic [COLOR_W-1:0] color_in_i,
  input  logic               ready_i,
  input  logic               abort_i,
  output logic [X_W-1:0]     x_o,
  output logic [Y_W-1:0]     y_o,
  output logic [COLOR_W-1:0] color_draw_o,
  output logic               plot_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [X_W-1:0] XMAX_C       = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YMAX_C       = Y_W'(Y_MAX);
  localparam logic [1:0]     MODE_OUTLINE = 2'b01;
  localparam logic [1:0]     MODE_CLEAR   = 2'b10;
  localparam logic [1:0]     MODE_RSVD    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t             state_q;
  logic [X_W-1:0]     x_q, xmin_q, xmax_q;
  logic [Y_W-1:0]     y_q, ymin_q, ymax_q;
  logic [COLOR_W-1:0] color_q;
  logic               outline_q, plot_q, busy_q, done_q;

  logic [X_W-1:0]     xmin_d, xmax_d;
  logic [Y_W-1:0]     ymin_d, ymax_d;
  logic [COLOR_W-1:0] color_d;
  logic               empty_d;

  // Sorted and clipped bounds of the requested primitive.
  always_comb begin
    xmin_d  = (x0_i < x1_i) ? x0_i : x1_i;
    xmax_d  = (x0_i < x1_i) ? x1_i : x0_i;
    ymin_d  = (y0_i < y1_i) ? y0_i : y1_i;
    ymax_d  = (y0_i < y1_i) ? y1_i : y0_i;
    color_d = color_in_i;
    empty_d = (xmin_d > XMAX_C) || (ymin_d > YMAX_C);
    if (xmax_d > XMAX_C) xmax_d = XMAX_C;
    if (ymax_d > YMAX_C) ymax_d = YMAX_C;
    if (mode_i == MODE_CLEAR) begin
      xmin_d  = '0;
      xmax_d  = XMAX_C;
      ymin_d  = '0;
      ymax_d  = YMAX_C;
      color_d = '0;
      empty_d = 1'b0;
    end
  end

  logic x_at_max, y_at_max, skip_interior;
  assign x_at_max      = (x_q == xmax_q);
  assign y_at_max      = (y_q == ymax_q);
  assign skip_interior = outline_q && (x_q == xmin_q) && (y_q != ymin_q) && !y_at_max;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymin_q    <= '0;
      ymax_q    <= '0;
      color_q   <= '0;
      outline_q <= 1'b0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!abort_i && start_i && (mode_i != MODE_RSVD)) begin
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
            outline_q <= (mode_i == MODE_OUTLINE);
            if (empty_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DRAW;
              x_q     <= xmin_d;
              y_q     <= ymin_d;
              color_q <= color_d;
              plot_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        S_DRAW: begin
          if (abort_i) begin
            state_q <= S_IDLE;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (ready_i) begin
            if (x_at_max && y_at_max) begin
              state_q <= S_DONE;
              plot_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (x_at_max) begin
              x_q <= xmin_q;
              y_q <= y_q + 1'b1;
            end else if (skip_interior) begin
              x_q <= xmax_q;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign color_draw_o = color_q;
  assign plot_o       = plot_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_plot_rect_engine.sv
// Bench for plot_rect_engine: vector table against a pixel scoreboard built
// from a loop-based rectangle model, plus abort/reset/ignored-start sequences.
module tb_plot_rect_engine;

  localparam int X_W = 8, Y_W = 8, C_W = 3, X_MAX = 159, Y_MAX = 119;
  localparam int BUDGET = 50000;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic [X_W-1:0] x0 = '0, x1 = '0;
  logic [Y_W-1:0] y0 = '0, y1 = '0;
  logic [C_W-1:0] color = '0;
  logic           ready = 1'b0;
  logic           abort = 1'b0;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [C_W-1:0] color_draw;
  logic           plot, busy, done;

  always #5 clk = ~clk;

  plot_rect_engine #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(C_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start), .mode_i(mode),
    .x0_i(x0), .x1_i(x1), .y0_i(y0), .y1_i(y1), .color_in_i(color),
    .ready_i(ready), .abort_i(abort),
    .x_o(x), .y_o(y), .color_draw_o(color_draw),
    .plot_o(plot), .busy_o(busy), .done_o(done)
  );

  typedef struct {
    logic [1:0] mode;
    int x0, x1, y0, y1;
    int col;
    int rdy;        // 0: always ready, 1: toggle 1,0,..., 2: random
    int exp_plots;
  } vec_t;

  typedef struct { int px; int py; int pc; } pix_t;

  vec_t vecs[11];
  pix_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pix(string name, int ex, int ey, int ec);
    n_checks++;
    if (plot !== 1'b1 || int'(x) != ex || int'(y) != ey || int'(color_draw) != ec) begin
      n_fail++;
      $display("FAIL %s: got plot=%0b (%0d,%0d,c%0d) expected plot=1 (%0d,%0d,c%0d)",
               name, plot, x, y, color_draw, ex, ey, ec);
    end
  endtask

  task automatic check_idle(string name);
    check({name, " plot"}, int'(plot), 0);
    check({name, " busy"}, int'(busy), 0);
    check({name, " done"}, int'(done), 0);
  endtask

  task automatic push_expected(vec_t v);
    int xl, xh, yl, yh, c;
    if (v.mode == 2'b10) begin
      xl = 0; xh = X_MAX; yl = 0; yh = Y_MAX; c = 0;
    end else begin
      xl = (v.x0 < v.x1) ? v.x0 : v.x1;
      xh = (v.x0 < v.x1) ? v.x1 : v.x0;
      yl = (v.y0 < v.y1) ? v.y0 : v.y1;
      yh = (v.y0 < v.y1) ? v.y1 : v.y0;
      if (xh > X_MAX) xh = X_MAX;
      if (yh > Y_MAX) yh = Y_MAX;
      c = v.col;
    end
    for (int yy = yl; yy <= yh; yy++)
      for (int xx = xl; xx <= xh; xx++)
        if (v.mode != 2'b01 || xx == xl || xx == xh || yy == yl || yy == yh)
          sb.push_back('{xx, yy, c});
  endtask

  // Called on a falling edge; returns on a falling edge.
  task automatic run_vec(int id);
    vec_t v;
    pix_t e;
    int accepted, done_cnt, done_cyc, last_acc, first_plot, post, hx, hy, hc;
    bit held;
    string tag;
    v = vecs[id];
    tag = $sformatf("v%0d", id);
    accepted = 0; done_cnt = 0; done_cyc = -1; last_acc = -1; first_plot = -1;
    post = -1; held = 0; hx = 0; hy = 0; hc = 0;
    push_expected(v);
    mode = v.mode; x0 = X_W'(v.x0); x1 = X_W'(v.x1); y0 = Y_W'(v.y0); y1 = Y_W'(v.y1);
    color = C_W'(v.col); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      case (v.rdy)
        0:       ready = 1'b1;
        1:       ready = (cyc % 2 == 1);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (held) check_pix({tag, " hold"}, hx, hy, hc);
      held = 0;
      if (plot) begin
        if (first_plot < 0) first_plot = cyc;
        if (ready) begin
          if (sb.size() == 0) check({tag, " extra plot"}, 1, 0);
          else begin
            e = sb.pop_front();
            check_pix({tag, " pixel"}, e.px, e.py, e.pc);
          end
          accepted++;
          last_acc = cyc;
        end else begin
          held = 1; hx = int'(x); hy = int'(y); hc = int'(color_draw);
        end
      end
      check({tag, " busy==plot"}, int'(busy), int'(plot));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check({tag, " plot during done"}, int'(plot), 0);
        if (post < 0) post = 2;
      end
      if (post == 0) break;
      if (post > 0) post--;
      @(negedge clk);
    end
    ready = 1'b0;
    check({tag, " plots"}, accepted, v.exp_plots);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " missing pixels"}, sb.size(), 0);
    if (v.exp_plots > 0) begin
      check({tag, " first plot latency"}, first_plot, 1);
      check({tag, " done after last"}, done_cyc, last_acc + 1);
    end else begin
      check({tag, " empty done latency"}, done_cyc, 1);
    end
    $display("vector %0d mode=%0d (%0d,%0d)-(%0d,%0d) plots=%0d done_cyc=%0d",
             id, v.mode, v.x0, v.y0, v.x1, v.y1, accepted, done_cyc);
    sb.delete();
  endtask

  initial begin
    vecs[0]  = '{2'b00,   5,   2,   3,   4, 5, 0, 8};
    vecs[1]  = '{2'b01,   0,   3,   0,   3, 2, 1, 12};
    vecs[2]  = '{2'b10,  40,  10,  20,  30, 7, 0, 19200};
    vecs[3]  = '{2'b00, 150, 200, 118, 130, 3, 0, 20};
    vecs[4]  = '{2'b00, 170, 170,  10,  20, 4, 0, 0};
    vecs[5]  = '{2'b01,   4,   4,   6,   2, 1, 2, 5};
    vecs[6]  = '{2'b01,   8,   3,   5,   5, 6, 1, 6};
    vecs[7]  = '{2'b00,   1,   1,   1,   1, 7, 0, 1};
    vecs[8]  = '{2'b01,  12,  10,  22,  20, 5, 2, 8};
    vecs[9]  = '{2'b00,   0,   2, 255, 117, 2, 2, 9};
    vecs[10] = '{2'b01, 158, 255,   0,   2, 3, 0, 6};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset x", int'(x), 0);
    check("reset y", int'(y), 0);
    check("reset color", int'(color_draw), 0);
    check_idle("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(i);

    // Abort after the 3rd accepted pixel of a 4x4 fill, then restart.
    mode = 2'b00; x0 = 0; x1 = 3; y0 = 0; y1 = 3; color = 6; start = 1'b1; ready = 1'b1;
    @(negedge clk); start = 1'b0;
    check_pix("abort px1", 0, 0, 6);
    @(negedge clk); check_pix("abort px2", 1, 0, 6);
    @(negedge clk); check_pix("abort px3", 2, 0, 6);
    @(negedge clk); abort = 1'b1; ready = 1'b0;
    check_pix("abort px4 shown", 3, 0, 6);
    @(negedge clk); abort = 1'b0;
    check_idle("after abort");
    mode = 2'b00; x0 = 7; x1 = 7; y0 = 8; y1 = 8; color = 1; start = 1'b1;
    @(negedge clk); start = 1'b0; ready = 1'b1;
    check_pix("restart px", 7, 8, 1);
    @(negedge clk); check("restart done", int'(done), 1);
    @(negedge clk); check("restart done pulse width", int'(done), 0);
    $display("sequence abort/restart complete");

    // Start held during DRAW and DONE is neither honoured nor queued.
    mode = 2'b00; x0 = 0; x1 = 1; y0 = 0; y1 = 0; color = 2; start = 1'b1;
    @(negedge clk); x0 = 9; x1 = 9; y0 = 9; y1 = 9;
    check_pix("busy-start px1", 0, 0, 2);
    @(negedge clk); check_pix("busy-start px2", 1, 0, 2);
    @(negedge clk); check("busy-start done", int'(done), 1);
    @(negedge clk); start = 1'b0;
    check_idle("start in DONE ignored");
    @(negedge clk); check_idle("start in DONE not queued");
    $display("sequence start-while-busy complete");

    // Start and abort together in IDLE: abort wins.
    mode = 2'b00; x0 = 1; x1 = 2; y0 = 1; y1 = 2; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check_idle("start+abort");
    @(negedge clk); check_idle("start+abort later");
    $display("sequence start+abort complete");

    // Reset asserted mid-DRAW.
    mode = 2'b00; x0 = 10; x1 = 20; y0 = 10; y1 = 20; color = 7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1 check_pix("reset waits for edge", 13, 10, 7);
    @(negedge clk);
    check("mid reset x", int'(x), 0);
    check("mid reset y", int'(y), 0);
    check("mid reset color", int'(color_draw), 0);
    check_idle("mid reset");
    reset_n = 1'b1;
    @(negedge clk); check_idle("after reset release");
    $display("sequence reset mid-DRAW complete");

    // Reserved mode is ignored.
    mode = 2'b11; x0 = 1; x1 = 4; y0 = 1; y1 = 4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_idle("mode 11");
      @(negedge clk);
    end
    $display("sequence reserved mode complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
